// File: rtl/axi_mm2s_fifo.sv
// AXI4 read slave serving bursts from a buffered AXI-Stream input.
// One R beat consumes one stream word; optional timeout turns underflow into SLVERR beats.
module axi_mm2s_fifo #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned UNDERFLOW_MODE = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                          axi_clk,
    input  logic                          axi_resetn,
    input  logic [ID_WIDTH-1:0]           s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [ID_WIDTH-1:0]           s_axi_rid,
    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   err_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 9;
    localparam int unsigned TMO_W = 16;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {S_IDLE, S_BURST} state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic [15:0]           errc_q, errc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      lvl_q, lvl_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic full, empty, idle, push, pop, ar_hs, r_hs, rvalid;
    logic unused_ok;

    assign unused_ok = ^{s_axi_araddr, s_axis_tlast, s_axis_tkeep};

    assign full   = (lvl_q == LVL_W'(FIFO_DEPTH));
    assign empty  = (lvl_q == '0);
    assign idle   = (state_q == S_IDLE);
    assign rvalid = (state_q == S_BURST) && (!empty || err_q);
    assign ar_hs  = s_axi_arvalid && idle;
    assign r_hs   = rvalid && s_axi_rready;
    assign push   = s_axis_tvalid && !full;
    assign pop    = r_hs && !err_q;

    // Ready outputs are forced low while reset is held; R channel is zero whenever not valid.
    assign s_axi_arready = axi_resetn && idle;
    assign s_axis_tready = axi_resetn && !full;
    assign s_axi_rvalid  = rvalid;
    assign s_axi_rid     = rvalid ? id_q : '0;
    assign s_axi_rdata   = (rvalid && !err_q) ? mem_q[rd_ptr_q] : '0;
    assign s_axi_rresp   = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast   = rvalid && (cnt_q == CNT_W'(1));
    assign fifo_level    = lvl_q;
    assign err_count     = errc_q;

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        lvl_d = lvl_q + LVL_W'(push) - LVL_W'(pop);
    end

    // Burst sequencing and underflow timeout.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        errc_d  = errc_q;
        case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    id_d    = s_axi_arid;
                    cnt_d   = CNT_W'(s_axi_arlen) + CNT_W'(1);
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (r_hs) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    tmo_d = '0;
                    if (err_q) begin
                        err_d = 1'b0;
                        if (errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
                    end
                    if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
                end else if ((UNDERFLOW_MODE != 0) && empty && !err_q) begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            errc_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
        end
    end

    // Storage needs no reset: contents are only visible once the level says so.
    always_ff @(posedge axi_clk) begin
        if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_axi_mm2s_fifo.sv
// Bench for axi_mm2s_fifo: a stall-mode and a timeout-mode instance checked every cycle
// against a queue-based model of the stream buffer and burst rules.
module tb_axi_mm2s_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 5;
    localparam int unsigned TMO1  = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [IW-1:0]  arid [2];
    logic [AW-1:0]  araddr [2];
    logic [7:0]     arlen [2];
    logic           arvalid [2], arready [2];
    logic [IW-1:0]  rid [2];
    logic [DW-1:0]  rdata [2];
    logic [1:0]     rresp [2];
    logic           rlast [2], rvalid [2], rready [2];
    logic           tvalid [2], tready [2], tlast [2];
    logic [DW-1:0]  tdata [2];
    logic [DW/8-1:0] tkeep [2];
    logic [LW-1:0]  level [2];
    logic [15:0]    errc [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_mm2s_fifo #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH),
            .UNDERFLOW_MODE(g), .TIMEOUT_CYCLES(g == 0 ? 256 : TMO1)
        ) u_dut (
            .axi_clk(clk), .axi_resetn(resetn),
            .s_axi_arid(arid[g]), .s_axi_araddr(araddr[g]), .s_axi_arlen(arlen[g]),
            .s_axi_arvalid(arvalid[g]), .s_axi_arready(arready[g]),
            .s_axi_rid(rid[g]), .s_axi_rdata(rdata[g]), .s_axi_rresp(rresp[g]),
            .s_axi_rlast(rlast[g]), .s_axi_rvalid(rvalid[g]), .s_axi_rready(rready[g]),
            .s_axis_tvalid(tvalid[g]), .s_axis_tready(tready[g]), .s_axis_tdata(tdata[g]),
            .s_axis_tlast(tlast[g]), .s_axis_tkeep(tkeep[g]),
            .fifo_level(level[g]), .err_count(errc[g])
        );
    end

    // Reference model: words accepted from the stream, and the open burst.
    logic [DW-1:0] mq [2][$];
    bit            inb [2], errp [2], hold [2], dut_arhs [2];
    int            left [2], w [2], ecnt [2], dut_beats [2], dut_lasts [2];
    logic [IW-1:0] mid [2];
    logic [42:0]   held [2];
    int            total = 0;
    int            bad = 0;

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL dut%0d %s: got %0h want %0h", d, tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            arvalid[d] = 1'b0;
            rready[d]  = 1'b0;
            tvalid[d]  = 1'b0;
        end
    endtask

    // One clock: check both instances at the falling edge, then advance the model.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit ev, ahs, rhs, push;
            logic [DW-1:0] ed;
            ev = inb[d] && (mq[d].size() != 0 || errp[d]);
            ed = (ev && !errp[d]) ? mq[d][0] : '0;
            chk(d, "arready", 64'(arready[d]), 64'(!inb[d]));
            chk(d, "tready", 64'(tready[d]), 64'(mq[d].size() < DEPTH));
            chk(d, "fifo_level", 64'(level[d]), 64'(mq[d].size()));
            chk(d, "err_count", 64'(errc[d]), 64'(ecnt[d]));
            chk(d, "rvalid", 64'(rvalid[d]), 64'(ev));
            chk(d, "rid", 64'(rid[d]), ev ? 64'(mid[d]) : 64'(0));
            chk(d, "rdata", 64'(rdata[d]), 64'(ed));
            chk(d, "rresp", 64'(rresp[d]), (ev && errp[d]) ? 64'(2) : 64'(0));
            chk(d, "rlast", 64'(rlast[d]), 64'(ev && left[d] == 1));
            if (hold[d]) chk(d, "r_stable", 64'({rid[d], rresp[d], rlast[d], rdata[d]}), 64'(held[d]));
            hold[d] = rvalid[d] && !rready[d];
            held[d] = {rid[d], rresp[d], rlast[d], rdata[d]};
            dut_arhs[d] = arvalid[d] && arready[d];
            if (rvalid[d] && rready[d]) begin
                dut_beats[d]++;
                if (rlast[d]) dut_lasts[d]++;
            end
            ahs  = !inb[d] && arvalid[d];
            rhs  = ev && rready[d];
            push = tvalid[d] && (mq[d].size() < DEPTH);
            if (rhs) begin
                if (errp[d]) begin
                    errp[d] = 1'b0;
                    if (ecnt[d] < 65535) ecnt[d]++;
                end else begin
                    void'(mq[d].pop_front());
                end
                left[d]--;
                w[d] = 0;
                if (left[d] == 0) inb[d] = 1'b0;
            end else if (inb[d] && d == 1 && mq[d].size() == 0 && !errp[d]) begin
                w[d]++;
                if (w[d] == int'(TMO1)) errp[d] = 1'b1;
            end
            if (push) mq[d].push_back(tdata[d]);
            if (ahs) begin
                inb[d] = 1'b1; left[d] = int'(arlen[d]) + 1; mid[d] = arid[d];
                w[d] = 0; errp[d] = 1'b0;
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            if (tvalid[d] && dut_push_seen(d)) tdata[d] = tdata[d] + 1;
    endtask

    // The source advances its word whenever the model saw the previous one accepted.
    function automatic bit dut_push_seen(input int d);
        return (mq[d].size() != 0) && (mq[d][mq[d].size()-1] == tdata[d]);
    endfunction

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin arvalid[d] = 1'b1; tvalid[d] = 1'b1; end
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_arready", 64'(arready[d]), 64'(0));
            chk(d, "rst_tready", 64'(tready[d]), 64'(0));
            chk(d, "rst_rvalid", 64'(rvalid[d]), 64'(0));
            chk(d, "rst_rfields", 64'({rid[d], rresp[d], rlast[d], rdata[d]}), 64'(0));
            chk(d, "rst_level", 64'(level[d]), 64'(0));
            chk(d, "rst_errc", 64'(errc[d]), 64'(0));
            mq[d].delete();
            inb[d] = 1'b0; errp[d] = 1'b0; hold[d] = 1'b0;
            ecnt[d] = 0; w[d] = 0; left[d] = 0;
        end
        idle_inputs();
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic burst(input int d, input int len, input logic [7:0] id);
        arvalid[d] = 1'b1; arlen[d] = 8'(len); arid[d] = id;
        tick();
        arvalid[d] = 1'b0;
        chk(d, "ar_accept", 64'(dut_arhs[d]), 64'(1));
    endtask

    task automatic wait_idle(input int d, input int lim, output int n);
        n = 0;
        while (!arready[d] && n < lim) begin tick(); n++; end
        chk(d, "idle_timeout", 64'(arready[d]), 64'(1));
    endtask

    task automatic drain(input int d);
        int n;
        if (mq[d].size() != 0) begin
            tvalid[d] = 1'b0; rready[d] = 1'b1;
            burst(d, mq[d].size() - 1, 8'h0D);
            wait_idle(d, 40, n);
            rready[d] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b0;
        int lens [3] = '{0, 7, 255};
        int bi [2];
        resetn = 1'b0;
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
            arid[d] = '0; arlen[d] = '0; araddr[d] = $urandom; tlast[d] = 1'b0;
            tkeep[d] = 4'hF; tdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        tick();

        // Four words then one 4-beat burst.
        for (int i = 0; i < 4; i++) begin tvalid[0] = 1'b1; tdata[0] = 32'h11 * (i + 1); tick(); end
        tvalid[0] = 1'b0;
        burst(0, 3, 8'h5A);
        rready[0] = 1'b1;
        wait_idle(0, 20, n);
        chk(0, "s1_cycles", 64'(n), 64'(4));
        chk(0, "s1_level", 64'(level[0]), 64'(0));

        // Fill to full, then pull 16 while the source keeps pushing.
        rready[0] = 1'b0; tvalid[0] = 1'b1; tdata[0] = 32'h1000;
        repeat (20) tick();
        chk(0, "s2_full_level", 64'(level[0]), 64'(16));
        chk(0, "s2_tready_low", 64'(tready[0]), 64'(0));
        rready[0] = 1'b1;
        burst(0, 15, 8'h21);
        wait_idle(0, 40, n);
        drain(0);

        // Stall mode: empty FIFO holds rvalid low until data arrives.
        b0 = dut_beats[0];
        rready[0] = 1'b1; tvalid[0] = 1'b0;
        burst(0, 1, 8'h33);
        repeat (50) tick();
        chk(0, "s3_no_beat", 64'(dut_beats[0] - b0), 64'(0));
        tvalid[0] = 1'b1; tdata[0] = 32'hABCD0001; tick(); tvalid[0] = 1'b0;
        repeat (10) tick();
        chk(0, "s3_one_beat", 64'(dut_beats[0] - b0), 64'(1));
        chk(0, "s3_rvalid_low", 64'(rvalid[0]), 64'(0));
        tvalid[0] = 1'b1; tick(); tvalid[0] = 1'b0;
        wait_idle(0, 10, n);

        // Timeout mode: SLVERR beat after 8 empty cycles, held while a word arrives.
        rready[1] = 1'b0; tvalid[1] = 1'b0;
        burst(1, 0, 8'h77);
        repeat (7) tick();
        chk(1, "s4_not_yet", 64'(rvalid[1]), 64'(0));
        tick();
        chk(1, "s4_err_valid", 64'(rvalid[1]), 64'(1));
        chk(1, "s4_err_resp", 64'({rresp[1], rlast[1], rdata[1]}), 64'({2'b10, 1'b1, 32'h0}));
        tvalid[1] = 1'b1; tdata[1] = 32'hBEEF0001; tick(); tvalid[1] = 1'b0;
        repeat (2) tick();
        rready[1] = 1'b1; tick(); rready[1] = 1'b0;
        chk(1, "s4_errc", 64'(errc[1]), 64'(1));
        chk(1, "s4_level", 64'(level[1]), 64'(1));
        drain(1);

        // Random backpressure over back-to-back bursts of 1, 8 and 256 beats.
        for (int d = 0; d < 2; d++) begin
            bi[d] = 0; arvalid[d] = 1'b1; arlen[d] = 8'(lens[0]); arid[d] = 8'($urandom);
            tdata[d] = $urandom; dut_beats[d] = 0; dut_lasts[d] = 0;
        end
        n = 0;
        while ((bi[0] < 3 || !arready[0] || bi[1] < 3 || !arready[1]) && n < 4000) begin
            for (int d = 0; d < 2; d++) begin
                rready[d] = ($urandom_range(0, 3) != 0);
                tvalid[d] = ($urandom_range(0, 3) != 0);
            end
            tick();
            n++;
            for (int d = 0; d < 2; d++)
                if (dut_arhs[d]) begin
                    bi[d]++;
                    if (bi[d] < 3) begin arlen[d] = 8'(lens[bi[d]]); arid[d] = 8'($urandom); end
                    else arvalid[d] = 1'b0;
                end
        end
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
            chk(d, "s5_bursts", 64'(bi[d]), 64'(3));
            chk(d, "s5_beats", 64'(dut_beats[d]), 64'(265));
            chk(d, "s5_lasts", 64'(dut_lasts[d]), 64'(3));
            drain(d);
        end

        // Reset in the middle of an 8-beat burst with 5 words still buffered.
        tvalid[0] = 1'b1; tdata[0] = 32'h7000;
        repeat (7) tick();
        tvalid[0] = 1'b0;
        burst(0, 7, 8'h42);
        rready[0] = 1'b1;
        repeat (2) tick();
        chk(0, "s6_level_before", 64'(level[0]), 64'(5));
        do_reset();
        tick();
        chk(0, "s6_arready", 64'(arready[0]), 64'(1));
        chk(0, "s6_level", 64'(level[0]), 64'(0));
        chk(1, "s6_errc", 64'(errc[1]), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
